// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: handshake, payload, refresh and perf signals of one elastic pipeline stage
interface pipe_stage_elastic_if #(
  parameter int OP_W   = 7,
  parameter int CTRL_W = 8,
  parameter int OPER_W = 16,
  parameter int OPER_N = 4,
  parameter int SRC_W  = 3,
  parameter int SRC_N  = 2
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [OP_W-1:0]          in_op;
  logic [CTRL_W-1:0]        in_ctrl;
  logic [OPER_N*OPER_W-1:0] in_oper;
  logic [SRC_N*SRC_W-1:0]   in_src;
  logic                     upd_en;
  logic [SRC_W-1:0]         upd_sel;
  logic [OPER_W-1:0]        upd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [OP_W-1:0]          out_op;
  logic [CTRL_W-1:0]        out_ctrl;
  logic [OPER_N*OPER_W-1:0] out_oper;
  logic [SRC_N*SRC_W-1:0]   out_src;
  logic [15:0]              perf_stall_cnt;
  modport slave (
    input  flush, in_valid, in_op, in_ctrl, in_oper, in_src, upd_en, upd_sel, upd_data, out_ready,
    output in_ready, out_valid, out_op, out_ctrl, out_oper, out_src, perf_stall_cnt
  );
  modport master (
    output flush, in_valid, in_op, in_ctrl, in_oper, in_src, upd_en, upd_sel, upd_data, out_ready,
    input  in_ready, out_valid, out_op, out_ctrl, out_oper, out_src, perf_stall_cnt
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready stage with 2-entry skid, flush-to-NOP and operand refresh; PIPE_STAGE_PERF_EN adds a stall counter
module pipe_stage_elastic #(
  parameter int              OP_W   = 7,
  parameter logic [OP_W-1:0] NOP_OP = 7'b0000100,
  parameter int              CTRL_W = 8,
  parameter int              OPER_W = 16,
  parameter int              OPER_N = 4,
  parameter int              SRC_W  = 3,
  parameter int              SRC_N  = 2
) (
  input logic clk,
  input logic rst,
  pipe_stage_elastic_if.slave bus
);
  logic                     m_valid_q, m_valid_d, s_valid_q, s_valid_d, in_fire;
  logic [OP_W-1:0]          m_op_q, m_op_d, s_op_q, s_op_d;
  logic [CTRL_W-1:0]        m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [OPER_N*OPER_W-1:0] m_oper_q, m_oper_d, s_oper_q, s_oper_d;
  logic [SRC_N*SRC_W-1:0]   m_src_q, m_src_d, s_src_q, s_src_d;

  // advance main/skid entries, then refresh operands of whatever is valid after the edge
  always_comb begin
    {m_valid_d, m_op_d, m_ctrl_d, m_oper_d, m_src_d} = {m_valid_q, m_op_q, m_ctrl_q, m_oper_q, m_src_q};
    {s_valid_d, s_op_d, s_ctrl_d, s_oper_d, s_src_d} = {s_valid_q, s_op_q, s_ctrl_q, s_oper_q, s_src_q};
    in_fire = bus.in_valid & ~s_valid_q;
    if (~m_valid_q | bus.out_ready) begin
      m_valid_d = s_valid_q | in_fire;
      {m_op_d, m_ctrl_d, m_oper_d, m_src_d} = s_valid_q ? {s_op_q, s_ctrl_q, s_oper_q, s_src_q}
                                                        : {bus.in_op, bus.in_ctrl, bus.in_oper, bus.in_src};
      s_valid_d = 1'b0;
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      {s_op_d, s_ctrl_d, s_oper_d, s_src_d} = {bus.in_op, bus.in_ctrl, bus.in_oper, bus.in_src};
    end
    for (int c = 0; c < SRC_N; c++) begin
      if (bus.upd_en && m_valid_d && m_src_d[c*SRC_W +: SRC_W] == bus.upd_sel)
        m_oper_d[c*OPER_W +: OPER_W] = bus.upd_data;
      if (bus.upd_en && s_valid_d && s_src_d[c*SRC_W +: SRC_W] == bus.upd_sel)
        s_oper_d[c*OPER_W +: OPER_W] = bus.upd_data;
    end
    if (bus.flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
  end

  // entry registers; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      {m_valid_q, m_op_q, m_ctrl_q, m_oper_q, m_src_q} <= '0;
      {s_valid_q, s_op_q, s_ctrl_q, s_oper_q, s_src_q} <= '0;
    end else begin
      {m_valid_q, m_op_q, m_ctrl_q, m_oper_q, m_src_q} <= {m_valid_d, m_op_d, m_ctrl_d, m_oper_d, m_src_d};
      {s_valid_q, s_op_q, s_ctrl_q, s_oper_q, s_src_q} <= {s_valid_d, s_op_d, s_ctrl_d, s_oper_d, s_src_d};
    end
  end

  assign bus.in_ready  = ~s_valid_q;
  assign bus.out_valid = m_valid_q;
  assign bus.out_op    = m_valid_q ? m_op_q : NOP_OP;
  assign bus.out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign bus.out_oper  = m_oper_q;
  assign bus.out_src   = m_src_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] perf_q, perf_d;

  // saturating count of cycles where the main entry is blocked downstream
  always_comb perf_d = (m_valid_q & ~bus.out_ready & ~&perf_q) ? perf_q + 16'd1 : perf_q;

  // stall counter register; only reset clears it
  always_ff @(posedge clk) perf_q <= rst ? 16'd0 : perf_d;

  assign bus.perf_stall_cnt = perf_q;
`else
  assign bus.perf_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed stimulus with a scoreboard queue checked by an independent output monitor
module tb_pipe_stage_elastic;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_elastic_if bus ();
  pipe_stage_elastic dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [6:0]  op;
    logic [7:0]  ctrl;
    logic [63:0] oper;
    logic [5:0]  src;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  ent_t e, e2;
  int errors = 0;
  int checks = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(logic [6:0] op, logic [15:0] o0, logic [15:0] o1, logic [2:0] s0, logic [2:0] s1);
    ent_t r;
    r.op   = op;
    r.ctrl = {1'b1, op};
    r.oper = {16'hC3C3, 16'h5A5A, o1, o0};
    r.src  = {s1, s0};
    return r;
  endfunction

  task automatic send(ent_t x);
    bus.in_valid = 1'b1;
    bus.in_op    = x.op;
    bus.in_ctrl  = x.ctrl;
    bus.in_oper  = x.oper;
    bus.in_src   = x.src;
  endtask

  // monitor: every accepted output must match the next expected entry
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual op=%h required=none", bus.out_op);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_op", {57'd0, bus.out_op}, {57'd0, mon_e.op});
        chk("out_ctrl", {56'd0, bus.out_ctrl}, {56'd0, mon_e.ctrl});
        chk("out_oper", bus.out_oper, mon_e.oper);
        chk("out_src", {58'd0, bus.out_src}, {58'd0, mon_e.src});
      end
    end
  end

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_ctrl = 0; bus.in_oper = 0; bus.in_src = 0;
    bus.upd_en = 0; bus.upd_sel = 0; bus.upd_data = 0; bus.out_ready = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_op", {57'd0, bus.out_op}, 64'h04);
    chk("rst_ctrl", {56'd0, bus.out_ctrl}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_perf", {48'd0, bus.perf_stall_cnt}, 64'd0);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = mk(7'h11 + 7'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i), 3'd1, 3'd2);
      send(e);
      exp_q.push_back(e);
      tick();
      chk("stream_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("stream_op", {57'd0, bus.out_op}, 64'h11 + 64'(i));
    end
    bus.in_valid = 0;
    tick();
    chk("stream_drain", {63'd0, bus.out_valid}, 64'd0);

    bus.out_ready = 1'b0;
    e = mk(7'h21, 16'h2100, 16'h2101, 3'd0, 3'd4);
    send(e); exp_q.push_back(e);
    tick();
    chk("bp_first_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_first_op", {57'd0, bus.out_op}, 64'h21);
    e = mk(7'h22, 16'h2200, 16'h2201, 3'd6, 3'd7);
    send(e); exp_q.push_back(e);
    tick();
    chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_hold_op", {57'd0, bus.out_op}, 64'h21);
    bus.in_valid = 0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_second_op", {57'd0, bus.out_op}, 64'h22);
    chk("bp_ready_back", {63'd0, bus.in_ready}, 64'd1);
    tick();
    chk("bp_drain", {63'd0, bus.out_valid}, 64'd0);

    bus.out_ready = 1'b0;
    e = mk(7'h31, 16'h0000, 16'h1111, 3'd3, 3'd5);
    send(e);
    tick();
    e2 = mk(7'h32, 16'h7777, 16'h0000, 3'd1, 3'd3);
    send(e2);
    bus.upd_en = 1'b1; bus.upd_sel = 3'd3; bus.upd_data = 16'hBEEF;
    tick();
    bus.in_valid = 0; bus.upd_en = 0;
    chk("ref_oper0", {48'd0, bus.out_oper[15:0]}, 64'hBEEF);
    chk("ref_oper1_kept", {48'd0, bus.out_oper[31:16]}, 64'h1111);
    e.oper[15:0] = 16'hBEEF;
    e2.oper[31:16] = 16'hBEEF;
    exp_q.push_back(e);
    exp_q.push_back(e2);
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("ref_drain", {63'd0, bus.out_valid}, 64'd0);

    bus.out_ready = 1'b0;
    send(mk(7'h41, 16'h4100, 16'h4101, 3'd2, 3'd2));
    tick();
    send(mk(7'h42, 16'h4200, 16'h4201, 3'd2, 3'd2));
    tick();
    bus.in_valid = 0; bus.flush = 1'b1;
    tick();
    bus.flush = 0;
    chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_op", {57'd0, bus.out_op}, 64'h04);
    chk("flush_ctrl", {56'd0, bus.out_ctrl}, 64'd0);
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    send(mk(7'h43, 16'h4300, 16'h4301, 3'd2, 3'd2));
    tick();
    send(mk(7'h44, 16'h4400, 16'h4401, 3'd2, 3'd2));
    bus.flush = 1'b1;
    tick();
    bus.flush = 0; bus.in_valid = 0;
    chk("flush2_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush2_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("flush_no_ghost", {63'd0, bus.out_valid}, 64'd0);
    e = mk(7'h45, 16'h4500, 16'h4501, 3'd0, 3'd1);
    send(e); exp_q.push_back(e);
    tick();
    bus.in_valid = 0;
    chk("post_flush_op", {57'd0, bus.out_op}, 64'h45);
    tick();

`ifdef PIPE_STAGE_PERF_EN
    rst = 1'b1; tick(); rst = 1'b0;
    chk("perf_rst0", {48'd0, bus.perf_stall_cnt}, 64'd0);
    bus.out_ready = 1'b0;
    e = mk(7'h51, 16'h5100, 16'h5101, 3'd0, 3'd1);
    send(e); exp_q.push_back(e);
    tick();
    bus.in_valid = 0;
    repeat (5) tick();
    chk("perf_five", {48'd0, bus.perf_stall_cnt}, 64'd5);
    repeat (65535) tick();
    chk("perf_sat", {48'd0, bus.perf_stall_cnt}, 64'hFFFF);
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("perf_clear", {48'd0, bus.perf_stall_cnt}, 64'd0);
`else
    chk("perf_const0", {48'd0, bus.perf_stall_cnt}, 64'd0);
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed D/X stage register: one generic pipeline stage with a valid/ready handshake, a 2-entry skid buffer, flush-to-NOP, and operand refresh for held entries.
- An entry whose source register matches a late writeback captures that data, so stalled operands never go stale.
- Instantiated between D/X, X/M and M/W with different widths.

Parameters:
- OP_W, 7, opcode+extension field width
- NOP_OP, 7'b0000100, op value driven and held when the stage is empty, flushed or in reset
- CTRL_W, 8, misc control bits (halt, write-enable, set-in, ...); zero when empty
- OPER_W, 16, operand word width
- OPER_N, 4, operand channels (e.g. ALU A, ALU B, memData, writeData)
- SRC_W, 3, register-select width
- SRC_N, 2, source-select channels; channel i<SRC_N tags operand i; legal range 1..OPER_N

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, equals ~skid_valid
- in_op  in  OP_W  opcode
- in_ctrl  in  CTRL_W  controls
- in_oper  in  OPER_N*OPER_W  operands, channel i at [i*OPER_W +: OPER_W]
- in_src  in  SRC_N*SRC_W  source selects
- upd_en  in  1  refresh write valid
- upd_sel  in  SRC_W  refresh register number
- upd_data  in  OPER_W  refresh value
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_op  out  OP_W  main op
- out_ctrl  out  CTRL_W  main controls
- out_oper  out  OPER_N*OPER_W  main operands
- out_src  out  SRC_N*SRC_W  main source selects
- perf_stall_cnt  out  16  see Optional Feature

Behaviour:
- State: main entry M (drives out_*) and skid entry S, each with a valid bit.
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- Reset (rst=1 at clk edge):
  - M and S invalid; all data zero; out_op=NOP_OP; in_ready=1.
  - Takes priority over everything else.
- Flush (rst=0, flush=1):
  - M and S invalid; out_op=NOP_OP; out_ctrl=0. Operand and src fields may keep old values.
  - A same-cycle in_fire is discarded.
  - in_ready=1 the next cycle.
- Normal cycle, evaluated on the state before the edge:
  - M empty or out_fire, S valid: M<=S, S<=in (if in_fire), else S invalid.
  - M empty or out_fire, S empty: M<=in if in_fire, else M invalid.
  - M valid and no out_fire: M holds; in_fire writes S. in_fire is legal only when S is empty, so in_ready=0 next cycle.
- Latency: 1 cycle input to output with no backpressure; full throughput at out_ready=1.
- No combinational path from out_ready to in_ready.
- Operand refresh, applied when upd_en=1:
  - For every entry that is valid after the edge, and every channel c<SRC_N with src[c]==upd_sel, oper[c] is written with upd_data.
  - This covers entries loaded from in or S that same cycle.
  - Register 0 is not special.
  - Channels >=SRC_N are never refreshed.
- Invalid M: out_op=NOP_OP and out_ctrl=0 always, so downstream decode sees NOP.
- Data is invisible when out_valid=0. Only op/ctrl are guaranteed.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - perf_stall_cnt counts cycles with out_valid=1 & out_ready=0.
  - 16-bit, saturating at 16'hFFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: perf_stall_cnt is constant 0 and no counter logic is generated.

Test Plan:
- Reset, then idle:
  - out_valid=0, out_op=7'b0000100, out_ctrl=0, in_ready=1.
  - With PIPE_STAGE_PERF_EN, perf_stall_cnt=0.
- Stream 3 entries (op 7'h11/7'h12/7'h13) with out_ready=1:
  - Each appears one cycle after acceptance, in order, with no bubbles.
- Backpressure:
  - Stimulus: out_ready=0 while sending op 7'h21 then 7'h22.
  - M=7'h21; S=7'h22; in_ready=0 next cycle.
  - After out_ready=1: 7'h21 then 7'h22 on consecutive cycles; in_ready returns to 1.
- Refresh:
  - Stimulus: hold M with src0=3, oper0=16'h0000; pulse upd_en, upd_sel=3, upd_data=16'hBEEF.
  - oper0=16'hBEEF; oper1 (src1=5) unchanged.
  - Refresh in the same cycle as acceptance of an entry with src1=3 also lands.
- Flush:
  - Stimulus: flush with M and S valid and in_fire same cycle.
  - Next cycle: out_valid=0, out_op=NOP_OP, in_ready=1; the flushed entries never appear.
- Perf counter (PIPE_STAGE_PERF_EN defined):
  - 5 cycles of out_valid=1, out_ready=0 gives perf_stall_cnt=5.
  - Preload near 16'hFFFF and stall; the count saturates at 16'hFFFF.
  - A rst pulse clears it to 0.
